instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the branch/next-PC logic.
- Holds the architectural PC, fetches one 32-bit instruction per handshake from instruction memory, and presents the instruction register IR, PC and PC_plus (PC+4) to decode and branch control.
- When downstream accepts the instruction, the PC is reloaded from NPC, which branch control computes from PC_plus, A, B and BRANCH.
- Multi-cycle, non-pipelined: one instruction in flight at a time.

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: holds PC, fetches one word per handshake, presents IR/PC/PC_plus.
// Optional FETCH_COUNT_EN adds a 32-bit accepted-instruction counter output fetch_count.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic [31:0] PC_plus,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [31:0] NPC,
    output logic        fetch_fault
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        HOLD   = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, valid_q, fault_q;
    logic             accept;

    // Next-state, datapath updates and the accept strobe
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = '0;
        accept  = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (start) state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (NPC[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = NPC;
                        accept  = 1'b1;
                        state_d = halt_req ? HALTED : REQ;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            req_q   <= (state_d == REQ);
            valid_q <= (state_d == HOLD);
            fault_q <= (state_d == FAULT);
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (accept) begin
            fcnt_q <= fcnt_q + 32'd1;
        end
    end

    assign fetch_count = fcnt_q;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign IR          = ir_q;
    assign PC          = pc_q;
    assign PC_plus     = pc_q + 32'd4;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: transaction-level reference model checked every cycle plus literal checks.
module tb_instr_fetch_unit;

    localparam int          TO  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_SHOW  = 2;
    localparam int M_HALT  = 3;
    localparam int M_DEAD  = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, halt_req, imem_ack, instr_ready;
    logic [31:0] imem_rdata, NPC;
    logic        imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, IR, PC, PC_plus;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IR          (IR),
        .PC          (PC),
        .PC_plus     (PC_plus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .NPC         (NPC),
        .fetch_fault (fetch_fault)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: what is being shown, how long the current fetch has waited, what was accepted
    int          m_mode;
    int          m_wait;
    logic [31:0] m_pc, m_ir, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_wait <= 0;
            m_pc   <= RPC;
            m_ir   <= 32'h0;
            m_cnt  <= 32'h0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: if (start) begin
                    m_mode <= M_FETCH;
                    m_wait <= 0;
                end
                M_FETCH: begin
                    if (imem_ack) begin
                        m_ir   <= imem_rdata;
                        m_mode <= M_SHOW;
                    end else if (m_wait + 1 >= TO) begin
                        m_mode <= M_DEAD;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                M_SHOW: if (instr_ready) begin
                    if (NPC % 4 != 0) begin
                        m_mode <= M_DEAD;
                    end else begin
                        m_pc   <= NPC;
                        m_cnt  <= m_cnt + 32'd1;
                        m_wait <= 0;
                        m_mode <= halt_req ? M_HALT : M_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("m_req",   32'(imem_req),    32'(m_mode == M_FETCH));
        check("m_valid", 32'(instr_valid), 32'(m_mode == M_SHOW));
        check("m_fault", 32'(fetch_fault), 32'(m_mode == M_DEAD));
        check("m_addr",  imem_addr, m_pc);
        check("m_pc",    PC,        m_pc);
        check("m_pcp",   PC_plus,   m_pc + 32'd4);
        check("m_ir",    IR,        m_ir);
`ifdef FETCH_COUNT_EN
        check("m_fcnt",  fetch_count, m_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'h0; instr_ready = 1'b0; NPC = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(imem_req),    32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_fault", 32'(fetch_fault), 32'h0);
        check("rst_pc",    PC,               32'h0);
        check("rst_ir",    IR,               32'h0);
        rst_n = 1'b1;

        // Zero-wait fetch then accept with NPC=4
        start = 1'b1; step();
        check("t1_req", 32'(imem_req), 32'h1);
        start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678; step();
        check("t1_ir",    IR,      32'h1234_5678);
        check("t1_pc",    PC,      32'h0);
        check("t1_pcp",   PC_plus, 32'h4);
        check("t1_valid", 32'(instr_valid), 32'h1);
        imem_ack = 1'b0; instr_ready = 1'b1; NPC = 32'h4; start = 1'b1; step();
        check("t1_addr2", imem_addr, 32'h4);

        // Ack on the third request cycle
        start = 1'b0; instr_ready = 1'b0; step();
        step();
        check("t2_req3", 32'(imem_req), 32'h1);
        check("t2_addr3", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001; step();
        check("t2_ir", IR, 32'hA5A5_0001);
        imem_ack = 1'b0; instr_ready = 1'b1; NPC = 32'h8; step();

        // No ack: fault after four request cycles
        instr_ready = 1'b0;
        repeat (3) step();
        check("t3_req4", 32'(imem_req), 32'h1);
        step();
        check("t3_fault", 32'(fetch_fault), 32'h1);
        check("t3_req",   32'(imem_req),    32'h0);
        check("t3_pc",    PC,               32'h8);
        start = 1'b1; repeat (2) step();
        check("t3_sticky", 32'(fetch_fault), 32'h1);
        start = 1'b0;
        do_reset();

        // Ack on the fourth request cycle wins over timeout, then misaligned NPC
        start = 1'b1; step();
        start = 1'b0; repeat (3) step();
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0004; step();
        check("t4_valid", 32'(instr_valid), 32'h1);
        check("t4_nofault", 32'(fetch_fault), 32'h0);
        imem_ack = 1'b0; instr_ready = 1'b1; NPC = 32'h0000_0006; step();
        check("t4_fault", 32'(fetch_fault), 32'h1);
        check("t4_pc", PC, 32'h0);
        instr_ready = 1'b0;
        do_reset();

        // PC wrap, halt at acceptance, resume
        start = 1'b1; step();
        start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_2222; step();
        imem_ack = 1'b0; instr_ready = 1'b1; NPC = 32'hFFFF_FFFC; step();
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        check("t5_wrap", PC_plus, 32'h0);
        instr_ready = 1'b0; halt_req = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D; step();
        check("t5_valid", 32'(instr_valid), 32'h1);
        imem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1; NPC = 32'h40; step();
        check("t5_halt_req", 32'(imem_req), 32'h0);
        check("t5_halt_pc",  PC, 32'h40);
        check("t5_halt_ir",  IR, 32'h0BAD_F00D);
        instr_ready = 1'b0; halt_req = 1'b0; repeat (2) step();
        imem_ack = 1'b0; start = 1'b1; step();
        check("t5_resume", imem_addr, 32'h40);
        check("t5_rreq", 32'(imem_req), 32'h1);
        start = 1'b0;
        do_reset();

        // Five back-to-back instructions
`ifdef FETCH_COUNT_EN
        check("t6_cnt0", fetch_count, 32'h0);
`endif
        start = 1'b1; step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'h5000_0000 + 32'(i); step();
            imem_ack = 1'b0; instr_ready = 1'b1; NPC = 32'h100 + 32'(4 * i); step();
            instr_ready = 1'b0;
        end
        check("t6_pc", PC, 32'h110);
`ifdef FETCH_COUNT_EN
        check("t6_cnt5", fetch_count, 32'h5);
`endif

        // Asynchronous reset in the middle of a request
        #2 rst_n = 1'b0;
        #1;
        check("t7_req", 32'(imem_req), 32'h0);
        check("t7_pc",  PC, RPC);
`ifdef FETCH_COUNT_EN
        check("t7_cnt", fetch_count, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
